// File: rtl/sdpram_bwe.sv
// Simple-dual-port RAM with byte-lane write enables, 0/1/2-cycle read latency,
// selectable same-address collision policy and a built-in array clear engine.
module sdpram_bwe #(
  parameter string       RAM_STYLE    = "distributed",
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       WRITE_MODE   = "read_first"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_req,
  output logic                            busy,
  input  logic                            we,
  input  logic [(DATA_WIDTH+7)/8-1:0]     wbe,
  input  logic [ADDR_WIDTH-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic                            re,
  input  logic [ADDR_WIDTH-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic                            dout_valid
);

  localparam int unsigned BE_WIDTH = (DATA_WIDTH + 7) / 8;
  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;

  if (READ_LATENCY > 2) begin : g_bad_latency
    $error("sdpram_bwe: READ_LATENCY must be 0, 1 or 2");
  end
  if (READ_LATENCY == 0 && RAM_STYLE == "block") begin : g_bad_style
    $error("sdpram_bwe: block RAM cannot provide a combinational read");
  end
  if (WRITE_MODE != "read_first" && WRITE_MODE != "write_first") begin : g_bad_mode
    $error("sdpram_bwe: WRITE_MODE must be read_first or write_first");
  end

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   sweep_addr, sweep_addr_next;
  logic                    rd_accept;
  logic [DATA_WIDTH-1:0]   rd_word;

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clear engine state register; busy mirrors the next state so it is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_CLEAR;
      sweep_addr <= '0;
      busy       <= 1'b1;
    end else begin
      state      <= state_next;
      sweep_addr <= sweep_addr_next;
      busy       <= (state_next == S_CLEAR);
    end
  end

  always_comb begin
    state_next      = state;
    sweep_addr_next = sweep_addr;
    case (state)
      S_CLEAR: begin
        sweep_addr_next = sweep_addr + ADDR_WIDTH'(1);
        if (sweep_addr == ADDR_WIDTH'(DEPTH - 1)) begin
          state_next      = S_IDLE;
          sweep_addr_next = '0;
        end
      end
      S_IDLE: begin
        if (clr_req) state_next = S_CLEAR;
      end
      default: state_next = S_CLEAR;
    endcase
  end

  // The sweep owns the write port while busy; user writes go lane by lane.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[sweep_addr] <= '0;
    end else if (we) begin
      for (int b = 0; b < int'(DATA_WIDTH); b++) begin
        if (wbe[b/8]) mem[waddr][b] <= din[b];
      end
    end
  end

  assign rd_accept = re & ~busy;
  assign rd_word   = mem[raddr];

  if (READ_LATENCY == 0) begin : g_lat0
    always_comb begin
      dout       = rd_word;
      dout_valid = rd_accept;
    end
  end else begin : g_lat12
    localparam bit WRITE_FIRST = (WRITE_MODE == "write_first");

    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] rd_fwd;
    logic                  collide;
    logic [DATA_WIDTH-1:0] d1;
    logic                  v1;

    always_comb begin
      wmask = '0;
      for (int b = 0; b < int'(DATA_WIDTH); b++) wmask[b] = wbe[b/8];
    end

    // write_first: the read sees the stored word merged with the enabled lanes
    assign collide = WRITE_FIRST && we && !busy && (waddr == raddr);
    assign rd_fwd  = collide ? ((rd_word & ~wmask) | (din & wmask)) : rd_word;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d1 <= '0;
        v1 <= 1'b0;
      end else begin
        v1 <= rd_accept;
        if (rd_accept) d1 <= rd_fwd;
      end
    end

    if (READ_LATENCY == 1) begin : g_lat1
      always_comb begin
        dout       = d1;
        dout_valid = v1;
      end
    end else begin : g_lat2
      logic [DATA_WIDTH-1:0] d2;
      logic                  v2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      always_comb begin
        dout       = d2;
        dout_valid = v2;
      end
    end
  end

  logic unused_be;
  assign unused_be = (BE_WIDTH == 0);

endmodule
